// File: rtl/chrisruk_strip_driver_if.sv
// Strip driver interface: groups the run controls and the pin-side outputs.
//   enable     run frames continuously while high
//   mode       pattern select: 00 off, 01 solid white, 10 chaser, 11 ramp
//   clock_out  shared strip clock
//   strip_out  one data line per strip
//   busy       high while a frame is shifting or latching
//   frame_done one-cycle pulse on the last latch cycle
// master: the host side that drives enable/mode; slave: the driver itself.
// N_STRIPS must match the N_STRIPS of the driver attached to it.
interface chrisruk_strip_driver_if #(
    parameter int N_STRIPS = 2
);
    logic                enable;
    logic [1:0]          mode;
    logic                clock_out;
    logic [N_STRIPS-1:0] strip_out;
    logic                busy;
    logic                frame_done;

    modport master (
        output enable,
        output mode,
        input  clock_out,
        input  strip_out,
        input  busy,
        input  frame_done
    );

    modport slave (
        input  enable,
        input  mode,
        output clock_out,
        output strip_out,
        output busy,
        output frame_done
    );
endinterface

// File: rtl/chrisruk_strip_driver.sv
// Multi-strip driver for clocked-serial (data + clock) LED strips.
// Shifts 24 bits per LED, LED0 first and MSB first, on N_STRIPS data lines that
// share one strip clock, then holds the clock low to latch the strips. Pixel data
// comes from a built-in pattern generator driven by an 8-bit frame counter.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   sif   slave side of chrisruk_strip_driver_if (enable/mode in;
//         clock_out/strip_out/busy/frame_done out, all registered)
//
// state | meaning
// IDLE  | clock and data low, waiting for enable
// SHIFT | clocking pixel bits out, CLK_DIV cycles low then CLK_DIV high per bit
// LATCH | clock and data low for LATCH_CYCLES, frame_done on the last cycle
module chrisruk_strip_driver #(
    parameter int N_STRIPS     = 2,
    parameter int N_LEDS       = 8,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    chrisruk_strip_driver_if.slave  sif
);
    localparam int LED_W = (N_LEDS > 1) ? $clog2(N_LEDS) : 1;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [LED_W-1:0] LAST_LED = LED_W'(N_LEDS - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [4:0]       TOP_BIT  = 5'd23;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          mode_q;
    logic [7:0]          frame_cnt;
    logic [DIV_W-1:0]    div_cnt;
    logic                phase_hi;
    logic [4:0]          bit_cnt;
    logic [LED_W-1:0]    led_cnt;
    logic [LAT_W-1:0]    latch_cnt;

    logic                clock_q;
    logic [N_STRIPS-1:0] strip_q;
    logic                busy_q;
    logic                done_q;

    // One data bit per strip for a given LED/bit position. There is no frame
    // buffer: every bit is recomputed from the LED counter and frame counter.
    function automatic logic [N_STRIPS-1:0] strip_bits(
        input logic [1:0]       m,
        input logic [LED_W-1:0] led,
        input logic [7:0]       f,
        input logic [4:0]       b
    );
        logic [N_STRIPS-1:0] bits;
        logic [7:0]          ramp;
        logic [23:0]         pix;
        int unsigned         lit;
        bits = '0;
        // 16*i + f, wrapping at 256
        ramp = 8'({led, 4'b0000}) + f;
        for (int s = 0; s < N_STRIPS; s++) begin
            lit = (32'(f) + 32'(s)) % 32'(N_LEDS);
            case (m)
                2'b00:   pix = 24'h000000;
                2'b01:   pix = 24'hFFFFFF;
                2'b10:   pix = (32'(led) == lit) ? 24'hFFFFFF : 24'h000000;
                default: pix = {ramp, ramp, ramp};
            endcase
            bits[s] = pix[b];
        end
        return bits;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 2'b00;
            frame_cnt <= 8'd0;
            div_cnt   <= '0;
            phase_hi  <= 1'b0;
            bit_cnt   <= 5'd0;
            led_cnt   <= '0;
            latch_cnt <= '0;
            clock_q   <= 1'b0;
            strip_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sif.enable) begin
                        state    <= SHIFT;
                        mode_q   <= sif.mode;
                        div_cnt  <= DIV_LOAD;
                        phase_hi <= 1'b0;
                        bit_cnt  <= TOP_BIT;
                        led_cnt  <= '0;
                        clock_q  <= 1'b0;
                        strip_q  <= strip_bits(sif.mode, '0, frame_cnt, TOP_BIT);
                        busy_q   <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (!phase_hi) begin
                            phase_hi <= 1'b1;
                            clock_q  <= 1'b1;
                        end else begin
                            // End of a high phase: the data line only ever moves
                            // here, together with the clock falling.
                            phase_hi <= 1'b0;
                            clock_q  <= 1'b0;
                            if (bit_cnt == 5'd0 && led_cnt == LAST_LED) begin
                                state     <= LATCH;
                                latch_cnt <= LAT_LOAD;
                                strip_q   <= '0;
                                done_q    <= (LATCH_CYCLES == 1);
                            end else if (bit_cnt == 5'd0) begin
                                bit_cnt <= TOP_BIT;
                                led_cnt <= led_cnt + 1'b1;
                                strip_q <= strip_bits(mode_q, led_cnt + 1'b1, frame_cnt, TOP_BIT);
                            end else begin
                                bit_cnt <= bit_cnt - 5'd1;
                                strip_q <= strip_bits(mode_q, led_cnt, frame_cnt, bit_cnt - 5'd1);
                            end
                        end
                    end
                end

                LATCH: begin
                    if (latch_cnt != '0) begin
                        latch_cnt <= latch_cnt - 1'b1;
                        done_q    <= (latch_cnt == LAT_W'(1));
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                        if (sif.enable) begin
                            // Back-to-back frame: pixels already use the advanced count.
                            state    <= SHIFT;
                            mode_q   <= sif.mode;
                            div_cnt  <= DIV_LOAD;
                            phase_hi <= 1'b0;
                            bit_cnt  <= TOP_BIT;
                            led_cnt  <= '0;
                            clock_q  <= 1'b0;
                            strip_q  <= strip_bits(sif.mode, '0, frame_cnt + 8'd1, TOP_BIT);
                            busy_q   <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    clock_q <= 1'b0;
                    strip_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sif.clock_out  = clock_q;
    assign sif.strip_out  = strip_q;
    assign sif.busy       = busy_q;
    assign sif.frame_done = done_q;

endmodule
